// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters,
// with a registered issue stage and a backpressured response stage.
module alu_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r0_valid,
    input  logic            r1_valid,
    output logic            r0_gnt,
    output logic            r1_gnt,
    input  logic [6:0]      r0_opcode,
    input  logic [6:0]      r1_opcode,
    input  logic [2:0]      r0_funct3,
    input  logic [2:0]      r1_funct3,
    input  logic [6:0]      r0_funct7,
    input  logic [6:0]      r1_funct7,
    input  logic            r0_alusrc,
    input  logic            r1_alusrc,
    input  logic [XLEN-1:0] r0_imm,
    input  logic [XLEN-1:0] r1_imm,
    input  logic [XLEN-1:0] r0_ValA,
    input  logic [XLEN-1:0] r1_ValA,
    input  logic [XLEN-1:0] r0_ValB,
    input  logic [XLEN-1:0] r1_ValB,
    output logic [6:0]      alu_opcode,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic            alu_alusrc,
    output logic [XLEN-1:0] alu_imm,
    output logic [XLEN-1:0] alu_ValA,
    output logic [XLEN-1:0] alu_ValB,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_carry,
    input  logic            alu_overflow,
    input  logic            alu_zero,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_carry,
    output logic            resp_overflow,
    output logic            resp_zero
);
    localparam int FW = 18 + 3 * XLEN;
    logic            r_a_valid;
    logic            r_a_id;
    logic            r_last;
    logic [FW-1:0]   r_a_fields;
    logic            r_resp_valid;
    logic            r_resp_id;
    logic            r_resp_carry;
    logic            r_resp_overflow;
    logic            r_resp_zero;
    logic [XLEN-1:0] r_resp_result;
    logic            w_b_free;
    logic            w_a_free;
    logic [FW-1:0]   w_req0;
    logic [FW-1:0]   w_req1;
    assign w_req0 = {r0_opcode, r0_funct3, r0_funct7, r0_alusrc, r0_imm, r0_ValA, r0_ValB};
    assign w_req1 = {r1_opcode, r1_funct3, r1_funct7, r1_alusrc, r1_imm, r1_ValA, r1_ValB};
    assign w_b_free = !r_resp_valid | resp_ready;
    // Gating with rst_n drops grants the instant reset asserts.
    assign w_a_free = (!r_a_valid | w_b_free) & rst_n;
    assign r0_gnt = w_a_free & r0_valid & (!r1_valid | r_last);
    assign r1_gnt = w_a_free & r1_valid & (!r0_valid | !r_last);
    assign {alu_opcode, alu_funct3, alu_funct7, alu_alusrc, alu_imm, alu_ValA, alu_ValB} = r_a_fields;
    assign resp_valid = r_resp_valid;
    assign resp_id = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_carry = r_resp_carry;
    assign resp_overflow = r_resp_overflow;
    assign resp_zero = r_resp_zero;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_id <= 1'b0;
            r_last <= 1'b1;
            r_a_fields <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id <= 1'b0;
            r_resp_result <= '0;
            r_resp_carry <= 1'b0;
            r_resp_overflow <= 1'b0;
            r_resp_zero <= 1'b0;
        end else begin
            if (r0_gnt | r1_gnt) begin
                r_a_valid <= 1'b1;
                r_a_id <= r1_gnt;
                r_a_fields <= r1_gnt ? w_req1 : w_req0;
                r_last <= r1_gnt;
            end else if (w_a_free) begin
                r_a_valid <= 1'b0;
            end
            if (w_b_free) begin
                r_resp_valid <= r_a_valid;
                if (r_a_valid) begin
                    r_resp_id <= r_a_id;
                    r_resp_result <= alu_result;
                    r_resp_carry <= alu_carry;
                    r_resp_overflow <= alu_overflow;
                    r_resp_zero <= alu_zero;
                end
            end
        end
    end
endmodule
